// File: rtl/dcache_pkg.sv
// Shared types and line/word helpers for the direct-mapped write-back data cache.
package dcache_pkg;

  localparam int OFFSET_W       = 5;
  localparam int LINE_W         = 256;
  localparam int WORD_W         = 32;
  localparam int WORDS_PER_LINE = 8;
  localparam int WSEL_W         = $clog2(WORDS_PER_LINE);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2,
    REFILLED  = 2'd3
  } state_e;

  // Word select within a line comes from byte-offset bits [4:2].
  function automatic logic [WSEL_W-1:0] word_sel(input logic [OFFSET_W-1:0] offset);
    return offset[OFFSET_W-1:2];
  endfunction

  function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                  input logic [WSEL_W-1:0] sel);
    return line[sel*WORD_W +: WORD_W];
  endfunction

  function automatic logic [LINE_W-1:0] line_merge(input logic [LINE_W-1:0] line,
                                                   input logic [WSEL_W-1:0] sel,
                                                   input logic [WORD_W-1:0] data);
    logic [LINE_W-1:0] merged;
    merged = line;
    merged[sel*WORD_W +: WORD_W] = data;
    return merged;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage: combinational read at one index, single-cycle line fill or word store.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 32,
  parameter int TAG_W     = 22,
  localparam int INDEX_W  = $clog2(NUM_LINES)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [INDEX_W-1:0] idx_i,
  input  logic               fill_i,
  input  logic [TAG_W-1:0]   fill_tag_i,
  input  logic [LINE_W-1:0]  fill_line_i,
  input  logic               store_i,
  input  logic [WSEL_W-1:0]  store_sel_i,
  input  logic [WORD_W-1:0]  store_data_i,
  output logic               valid_o,
  output logic               dirty_o,
  output logic [TAG_W-1:0]   tag_o,
  output logic [LINE_W-1:0]  line_o
);

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_W-1:0]    line_q [NUM_LINES];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_i) begin
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= 1'b0;
    end else if (store_i) begin
      dirty_q[idx_i] <= 1'b1;
    end
  end

  // NOTE: tag/data arrays are deliberately left out of reset; valid_q gates every use.
  always_ff @(posedge clk_i) begin
    if (fill_i) begin
      tag_q[idx_i]  <= fill_tag_i;
      line_q[idx_i] <= fill_line_i;
    end else if (store_i) begin
      line_q[idx_i] <= line_merge(line_q[idx_i], store_sel_i, store_data_i);
    end
  end

  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];
  assign tag_o   = tag_q[idx_i];
  assign line_o  = line_q[idx_i];

endmodule

// File: rtl/dcache_ctrl.sv
// MEM-stage data cache controller: hit logic, word merge and the miss FSM driving a line-wide memory handshake.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 32,
  parameter int ADDR_W    = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [31:0]       cpu_data_i,
  input  logic              cpu_MemRead_i,
  input  logic              cpu_MemWrite_i,
  output logic [31:0]       cpu_data_o,
  output logic              cpu_stall_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
);

  localparam int INDEX_W = $clog2(NUM_LINES);
  localparam int TAG_W   = ADDR_W - INDEX_W - OFFSET_W;

  state_e              state_q;
  logic                mem_enable_q;
  logic                mem_write_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [LINE_W-1:0]   mem_data_q;

  logic [TAG_W-1:0]    addr_tag;
  logic [INDEX_W-1:0]  addr_idx;
  logic [WSEL_W-1:0]   addr_sel;
  logic [1:0]          unused_byte_off;

  logic                arr_valid;
  logic                arr_dirty;
  logic [TAG_W-1:0]    arr_tag;
  logic [LINE_W-1:0]   arr_line;

  logic                req;
  logic                hit;
  logic                store_hit;
  logic                fill;

  assign addr_tag        = cpu_addr_i[ADDR_W-1 -: TAG_W];
  assign addr_idx        = cpu_addr_i[OFFSET_W +: INDEX_W];
  assign addr_sel        = word_sel(cpu_addr_i[OFFSET_W-1:0]);
  assign unused_byte_off = cpu_addr_i[1:0];

  assign req       = cpu_MemRead_i | cpu_MemWrite_i;
  assign hit       = arr_valid && (arr_tag == addr_tag);
  // A store wins over a simultaneous load, so only MemWrite decides the merge.
  assign store_hit = (state_q == IDLE) && cpu_MemWrite_i && hit;
  assign fill      = (state_q == ALLOCATE) && mem_ack_i;

  dcache_array #(
    .NUM_LINES (NUM_LINES),
    .TAG_W     (TAG_W)
  ) u_array (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .idx_i        (addr_idx),
    .fill_i       (fill),
    .fill_tag_i   (addr_tag),
    .fill_line_i  (mem_data_i),
    .store_i      (store_hit),
    .store_sel_i  (addr_sel),
    .store_data_i (cpu_data_i),
    .valid_o      (arr_valid),
    .dirty_o      (arr_dirty),
    .tag_o        (arr_tag),
    .line_o       (arr_line)
  );

  // NOTE: every output of an always_comb gets a default first so no latch is inferred.
  always_comb begin
    cpu_data_o  = '0;
    cpu_stall_o = 1'b1;
    if (state_q == IDLE) begin
      cpu_stall_o = req && !hit;
      if (cpu_MemRead_i && hit) begin
        cpu_data_o = line_word(arr_line, addr_sel);
      end
    end
  end

  // NOTE: all state uses non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req && !hit) begin
            mem_enable_q <= 1'b1;
            if (arr_valid && arr_dirty) begin
              state_q     <= WRITEBACK;
              mem_write_q <= 1'b1;
              mem_addr_q  <= {arr_tag, addr_idx, {OFFSET_W{1'b0}}};
              mem_data_q  <= arr_line;
            end else begin
              state_q     <= ALLOCATE;
              mem_write_q <= 1'b0;
              mem_addr_q  <= {addr_tag, addr_idx, {OFFSET_W{1'b0}}};
            end
          end
        end
        WRITEBACK: begin
          // Enable stays high: the fill request follows the write-back directly.
          if (mem_ack_i) begin
            state_q     <= ALLOCATE;
            mem_write_q <= 1'b0;
            mem_addr_q  <= {addr_tag, addr_idx, {OFFSET_W{1'b0}}};
          end
        end
        ALLOCATE: begin
          if (mem_ack_i) begin
            state_q      <= REFILLED;
            mem_enable_q <= 1'b0;
          end
        end
        REFILLED: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_enable_o = mem_enable_q;
  assign mem_write_o  = mem_write_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: word-level memory model, cache residency model and a per-cycle output monitor.
module tb_dcache_ctrl;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_data_i;
  logic         cpu_MemRead_i;
  logic         cpu_MemWrite_i;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;

  always #5 clk_i = ~clk_i;

  dcache_ctrl dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .cpu_addr_i     (cpu_addr_i),
    .cpu_data_i     (cpu_data_i),
    .cpu_MemRead_i  (cpu_MemRead_i),
    .cpu_MemWrite_i (cpu_MemWrite_i),
    .cpu_data_o     (cpu_data_o),
    .cpu_stall_o    (cpu_stall_o),
    .mem_addr_o     (mem_addr_o),
    .mem_data_o     (mem_data_o),
    .mem_enable_o   (mem_enable_o),
    .mem_write_o    (mem_write_o),
    .mem_data_i     (mem_data_i),
    .mem_ack_i      (mem_ack_i)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // CPU-visible memory (word granular), backing memory (line granular) and cache residency.
  logic [31:0]  fmem   [int];
  logic [255:0] mstore [int];
  logic         res_valid [32];
  logic         res_dirty [32];
  logic [21:0]  res_tag   [32];

  typedef struct {
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] data;
  } txn_t;
  txn_t txn_q[$];

  int ack_delay = 0;
  int ack_cnt   = 0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] cpu_view(input logic [31:0] a);
    int k;
    k = int'({a[31:2], 2'b00});
    return fmem.exists(k) ? fmem[k] : init_word(a);
  endfunction

  function automatic logic [255:0] model_line(input logic [31:0] base);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = cpu_view(base + 32'(w * 4));
    return l;
  endfunction

  function automatic logic [255:0] backing_line(input logic [31:0] base);
    logic [255:0] l;
    if (mstore.exists(int'(base))) return mstore[int'(base)];
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = init_word(base + 32'(w * 4));
    return l;
  endfunction

  task automatic clear_model();
    fmem.delete();
    mstore.delete();
    for (int i = 0; i < 32; i++) begin
      res_valid[i] = 1'b0;
      res_dirty[i] = 1'b0;
      res_tag[i]   = '0;
    end
  endtask

  // Backing memory: acks ack_delay cycles after it first sees a request.
  initial begin
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    forever begin
      @(negedge clk_i);
      mem_ack_i = 1'b0;
      if (rst_i || !mem_enable_o) begin
        ack_cnt = 0;
      end else begin
        ack_cnt++;
        if (ack_cnt == ack_delay + 1) begin
          ack_cnt   = 0;
          mem_ack_i = 1'b1;
          if (mem_write_o) mstore[int'(mem_addr_o)] = mem_data_o;
          else             mem_data_i = backing_line(mem_addr_o);
          txn_q.push_back('{mem_write_o, mem_addr_o, mem_data_o});
        end
      end
    end
  end

  // Per-cycle monitor of load data and memory-side outputs.
  initial begin
    forever begin
      @(negedge clk_i);
      if (rst_i !== 1'b0) continue;
      if (!cpu_MemRead_i)
        check("data_zero_no_load", cpu_data_o, 0);
      else if (!cpu_stall_o && !cpu_MemWrite_i)
        check("load_data", cpu_data_o, cpu_view(cpu_addr_i));
      if (!cpu_stall_o && cpu_MemWrite_i)
        fmem[int'({cpu_addr_i[31:2], 2'b00})] = cpu_data_i;
      if (mem_enable_o) begin
        check("mem_addr_align", mem_addr_o[4:0], 0);
        if (mem_write_o) check("wb_line", mem_data_o, model_line(mem_addr_o));
      end
    end
  end

  task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input int d,
                        output int lat, output logic [31:0] rdata);
    int          idx;
    logic [21:0] tag;
    logic        hit;
    logic        dirty_miss;
    int          exp_lat;
    logic [31:0] victim;
    logic [31:0] fill_addr;
    idx        = int'(addr[9:5]);
    tag        = addr[31:10];
    hit        = res_valid[idx] && (res_tag[idx] == tag);
    dirty_miss = !hit && res_valid[idx] && res_dirty[idx];
    exp_lat    = hit ? 0 : (dirty_miss ? 4 + 2 * d : 3 + d);
    victim     = {res_tag[idx], addr[9:5], 5'b0};
    fill_addr  = {addr[31:5], 5'b0};
    ack_delay  = d;
    txn_q.delete();
    cpu_addr_i     = addr;
    cpu_data_i     = data;
    cpu_MemRead_i  = rd;
    cpu_MemWrite_i = wr;
    lat = 0;
    forever begin
      @(negedge clk_i);
      if (!cpu_stall_o) break;
      lat++;
      if (lat > 200) begin
        check("stall_timeout", cpu_stall_o, 0);
        break;
      end
    end
    rdata = cpu_data_o;
    check("latency", lat, exp_lat);
    if (hit) begin
      check("hit_no_txn", txn_q.size(), 0);
    end else if (dirty_miss) begin
      check("dirty_txn_count", txn_q.size(), 2);
      if (txn_q.size() == 2) begin
        check("wb_is_write", txn_q[0].wr, 1);
        check("wb_addr", txn_q[0].addr, victim);
        check("fill_is_read", txn_q[1].wr, 0);
        check("fill_addr", txn_q[1].addr, fill_addr);
      end
    end else begin
      check("clean_txn_count", txn_q.size(), 1);
      if (txn_q.size() == 1) begin
        check("fill_is_read", txn_q[0].wr, 0);
        check("fill_addr", txn_q[0].addr, fill_addr);
      end
    end
    if (!hit) begin
      res_valid[idx] = 1'b1;
      res_tag[idx]   = tag;
      res_dirty[idx] = 1'b0;
    end
    if (wr) res_dirty[idx] = 1'b1;
    @(posedge clk_i);
    #1;
    cpu_MemRead_i  = 1'b0;
    cpu_MemWrite_i = 1'b0;
  endtask

  initial begin
    int          lat;
    logic [31:0] rd;
    int          n;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [31:0] rd;
    int          n;
    rst_i          = 1'b1;
    cpu_addr_i     = '0;
    cpu_data_i     = '0;
    cpu_MemRead_i  = 1'b0;
    cpu_MemWrite_i = 1'b0;
    clear_model();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_stall", cpu_stall_o, 0);
    check("rst_enable", mem_enable_o, 0);
    check("rst_write", mem_write_o, 0);
    check("rst_addr", mem_addr_o, 0);
    check("rst_mem_data", mem_data_o, 0);
    check("rst_cpu_data", cpu_data_o, 0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // Cold load: clean miss, fill line 0x40 after 10 cycles.
    do_req(1'b1, 1'b0, 32'h0000_0040, 32'h0, 10, lat, rd);
    check("cold_lat_lit", lat, 13);
    check("cold_data_lit", rd, 32'h5A5A_0040);
    if (txn_q.size() == 1) check("cold_fill_addr_lit", txn_q[0].addr, 32'h40);

    do_req(1'b1, 1'b0, 32'h0000_0044, 32'h0, 0, lat, rd);
    check("hit_lat_lit", lat, 0);
    check("hit_data_lit", rd, 32'h5A5A_0044);

    do_req(1'b0, 1'b1, 32'h0000_0048, 32'hDEAD_BEEF, 0, lat, rd);
    check("store_hit_lat_lit", lat, 0);
    do_req(1'b1, 1'b0, 32'h0000_0048, 32'h0, 0, lat, rd);
    check("store_readback_lit", rd, 32'hDEAD_BEEF);

    // Same index, new tag: dirty eviction of line 0x40 then fill of 0x440.
    do_req(1'b1, 1'b0, 32'h0000_0448, 32'h0, 2, lat, rd);
    check("evict_lat_lit", lat, 8);
    check("evict_data_lit", rd, 32'h5A5A_0448);
    if (txn_q.size() == 2) begin
      check("evict_wb_addr_lit", txn_q[0].addr, 32'h40);
      check("evict_wb_word2_lit", txn_q[0].data[95:64], 32'hDEAD_BEEF);
      check("evict_fill_addr_lit", txn_q[1].addr, 32'h440);
    end

    // MemRead and MemWrite together behave as a store.
    do_req(1'b1, 1'b1, 32'h0000_044C, 32'h1234_5678, 0, lat, rd);
    check("both_lat_lit", lat, 0);
    do_req(1'b1, 1'b0, 32'h0000_044C, 32'h0, 0, lat, rd);
    check("both_readback_lit", rd, 32'h1234_5678);

    // Evict 0x440 (dirty from the combined access) and reload 0x40 from memory.
    do_req(1'b1, 1'b0, 32'h0000_0040, 32'h0, 1, lat, rd);
    check("reload_lat_lit", lat, 6);
    if (txn_q.size() == 2) check("reload_wb_addr_lit", txn_q[0].addr, 32'h440);
    do_req(1'b1, 1'b0, 32'h0000_0048, 32'h0, 0, lat, rd);
    check("reload_retained_lit", rd, 32'hDEAD_BEEF);

    // Store miss: allocate then merge.
    do_req(1'b0, 1'b1, 32'h0000_1004, 32'hCAFE_F00D, 1, lat, rd);
    check("store_miss_lat_lit", lat, 4);
    do_req(1'b1, 1'b0, 32'h0000_1004, 32'h0, 0, lat, rd);
    check("store_miss_read_lit", rd, 32'hCAFE_F00D);
    do_req(1'b1, 1'b0, 32'h0000_1000, 32'h0, 0, lat, rd);
    check("store_miss_neighbour_lit", rd, 32'h5A5A_1000);

    // Reset while a fill is outstanding.
    ack_delay = 20;
    txn_q.delete();
    cpu_addr_i    = 32'h0000_2040;
    cpu_MemRead_i = 1'b1;
    n = 0;
    forever begin
      @(negedge clk_i);
      if (mem_enable_o && !mem_write_o) break;
      n++;
      if (n > 100) begin
        check("alloc_wait_timeout", mem_enable_o, 1);
        break;
      end
    end
    @(posedge clk_i);
    #1;
    rst_i         = 1'b1;
    cpu_MemRead_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    clear_model();
    @(negedge clk_i);
    check("midrst_enable", mem_enable_o, 0);
    check("midrst_stall", cpu_stall_o, 0);
    check("midrst_cpu_data", cpu_data_o, 0);
    check("midrst_no_ack", txn_q.size(), 0);
    @(posedge clk_i);
    #1;
    do_req(1'b1, 1'b0, 32'h0000_0040, 32'h0, 3, lat, rd);
    check("post_rst_lat_lit", lat, 6);
    check("post_rst_data_lit", rd, 32'h5A5A_0040);

    repeat (3) @(posedge clk_i);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache controller in the MEM stage.
- Consumes the EX/MEM latch outputs (ALU address, store data, MemRead/MemWrite) and returns load data to the MEM/WB latch.
- On a miss, stalls the whole pipeline and runs a line-wide handshake with the backing data memory.

Parameters:
- NUM_LINES, 32, number of cache lines (power of 2).
- LINE_W, 256, line width in bits (8 words).
- ADDR_W, 32, byte address width.
- Derived: OFFSET_W=5, INDEX_W=log2(NUM_LINES), TAG_W=ADDR_W-INDEX_W-OFFSET_W (22 at defaults).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- cpu_addr_i  in  ADDR_W  byte address from EX/MEM; bits [1:0] ignored
- cpu_data_i  in  32  store data
- cpu_MemRead_i  in  1  load request
- cpu_MemWrite_i  in  1  store request
- cpu_data_o  out  32  load data, valid when a load is present and cpu_stall_o=0
- cpu_stall_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM and MEM/WB
- mem_addr_o  out  ADDR_W  line-aligned address, bits [4:0]=0
- mem_data_o  out  LINE_W  victim line for write-back
- mem_enable_o  out  1  memory request, held until ack
- mem_write_o  out  1  1=write-back, 0=line fill
- mem_data_i  in  LINE_W  fill data, valid with mem_ack_i
- mem_ack_i  in  1  single-cycle completion pulse

Behaviour:
- Clock and reset: single clock clk_i; synchronous active-high reset rst_i.
- Reset effects: all valid and dirty bits cleared; FSM to IDLE; mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0, cpu_stall_o=0, cpu_data_o=0. Tag and data contents are don't-care.
- Request: req = cpu_MemRead_i | cpu_MemWrite_i. If both are set, the store takes priority; this is an illegal input but the behaviour is defined.
- Hit: hit = valid[idx] & (tag[idx]==addr_tag).
  - Load hit: cpu_data_o = selected word, combinational, same cycle, no stall.
  - Store hit: word at addr[4:2] written at the clock edge; dirty[idx]=1; no stall.
- States: IDLE, WRITEBACK, ALLOCATE, REFILLED.
- IDLE:
  - cpu_stall_o = req & ~hit, combinational.
  - On req & ~hit: go to WRITEBACK if valid & dirty, else ALLOCATE.
- WRITEBACK:
  - mem_enable_o=1, mem_write_o=1, mem_addr_o={victim tag, idx, 5'b0}, mem_data_o=victim line.
  - On mem_ack_i: go to ALLOCATE.
- ALLOCATE:
  - mem_enable_o=1, mem_write_o=0, mem_addr_o={addr_tag, idx, 5'b0}.
  - On mem_ack_i: line=mem_data_i, tag=addr_tag, valid=1, dirty=0; go to REFILLED.
- REFILLED: mem_enable_o=0; go to IDLE. The next cycle is a hit: a load returns data, a store merges and sets dirty.
- cpu_stall_o is 1 in WRITEBACK, ALLOCATE and REFILLED.
- The CPU holds cpu_* inputs stable while stalled.
- Miss latency: 3 + memory ack delay (clean), or 4 + two ack delays (dirty), counted from the miss cycle to the first unstalled cycle.
- Memory outputs are registered and stable for the whole request. mem_ack_i outside WRITEBACK or ALLOCATE is ignored.
- cpu_data_o is 0 when no load is present.
- Reset mid-transaction: returns immediately to IDLE and abandons the request; the backing memory shares rst_i.

Decomposition:
- Package dcache_pkg:
  - state enum (IDLE, WRITEBACK, ALLOCATE, REFILLED)
  - OFFSET_W, LINE_W, WORDS_PER_LINE=8
  - tag/index/offset slice helpers
- Sub-module dcache_array: tag, valid, dirty and data storage with single-cycle write and combinational read.
- dcache_ctrl holds the FSM, hit logic and word merge.

Test Plan:
- Cold load 0x0000_0040:
  - stall asserts the same cycle;
  - ALLOCATE request with mem_addr_o=0x40, mem_write_o=0;
  - after ack (delay 10), REFILLED then IDLE;
  - cpu_data_o = word 0 of the fill line.
- Load hit 0x44 after that fill -> cpu_stall_o=0 the same cycle; data = word 1.
- Store 0xDEADBEEF to 0x48 (hit) -> no stall; a later load of 0x48 returns 0xDEADBEEF; dirty[2]=1.
- Load 0x0000_0448 (same index, new tag) -> WRITEBACK at 0x40 carrying 0xDEADBEEF in word 2, then ALLOCATE at 0x440, then data returned.
- Simultaneous MemRead and MemWrite on a hit -> treated as a store; dirty set.
- rst_i pulsed during ALLOCATE:
  - next cycle IDLE, mem_enable_o=0, cpu_stall_o=0;
  - a subsequent load of 0x40 misses again.
